// File: rtl/spi_pkg.sv
// Shared SPI definitions: transaction FSM states, mode encodings and divider math.
// Pure definitions with no timing and no flow control.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam int SPI_MODE0 = 0;
    localparam int SPI_MODE3 = 3;

    // Core clocks per SCLK half-period; 0 flags an unusable frequency pair.
    function automatic int calc_divider(input int clk_hz, input int spi_hz);
        if (spi_hz <= 0) begin
            return 0;
        end
        return clk_hz / (2 * spi_hz);
    endfunction

endpackage

// File: rtl/spi_sclk_tick.sv
// Half-period tick generator: tick every DIVIDER cycles while clr_i is low.
// One-cycle tick pulse, counter restarts from 0 whenever cleared; no backpressure.
module spi_sclk_tick #(
    parameter int DIVIDER = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_burst.sv
// SPI master: one R/W header bit, ADDR_W address bits, then 1..MAX_BURST data words per start.
// All outputs registered; tx_data is taken at word boundaries (tx_req asks for the next one), rx has no backpressure.
module spi_master_burst
    import spi_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SPI_CLK   = 5_000_000,
    parameter int SPI_MODE  = 0,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8,
    parameter int NUM_CS    = 2,
    localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int LEN_W    = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              start,
    input  logic              rw,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);
    localparam int   DIVIDER = calc_divider(CLK_HZ, SPI_CLK);
    localparam logic CPOL    = (SPI_MODE == SPI_MODE3);
    localparam int   HC_W    = $clog2(ADDR_W + 1);
    localparam int   DB_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    if (DIVIDER < 1) begin : g_div_chk
        $error("spi_master_burst: CLK_HZ/(2*SPI_CLK) must be at least 1");
    end
    if ((SPI_MODE != SPI_MODE0) && (SPI_MODE != SPI_MODE3)) begin : g_mode_chk
        $error("spi_master_burst: SPI_MODE must be 0 or 3");
    end

    state_t            state_q, state_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              phase_q, phase_d;
    logic              in_data_q, in_data_d;
    logic              rw_q, rw_d;
    logic [HC_W-1:0]   hdr_cnt_q, hdr_cnt_d;
    logic [ADDR_W-1:0] hdr_sh_q, hdr_sh_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DB_W-1:0]   dbit_q, dbit_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_req_q, tx_req_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              tick;
    logic [LEN_W-1:0]  eff_len;
    logic              cs_bad;
    logic [NUM_CS-1:0] cs_sel_mask;
    logic [DATA_W-1:0] rx_next;
    logic              word_end;
    logic              last_bit;

    spi_sclk_tick #(
        .DIVIDER (DIVIDER)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    always_comb begin
        eff_len = burst_len;
        if (burst_len == '0) begin
            eff_len = LEN_W'(1);
        end else if (burst_len > LEN_W'(MAX_BURST)) begin
            eff_len = LEN_W'(MAX_BURST);
        end
    end

    assign cs_bad      = cs_sel > CS_W'(NUM_CS - 1);
    assign cs_sel_mask = ~(NUM_CS'(1) << cs_sel);
    assign rx_next     = DATA_W'({rx_sh_q, miso});
    assign word_end    = dbit_q == DB_W'(DATA_W - 1);
    assign last_bit    = in_data_q && word_end && (words_q == LEN_W'(1));

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        phase_d    = phase_q;
        in_data_d  = in_data_q;
        rw_d       = rw_q;
        hdr_cnt_d  = hdr_cnt_q;
        hdr_sh_d   = hdr_sh_q;
        tx_sh_d    = tx_sh_q;
        dbit_d     = dbit_q;
        words_d    = words_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if ((state_q != IDLE) && !enable) begin
            state_d = IDLE;
            cs_n_d  = '1;
            sclk_d  = CPOL;
            mosi_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && start) begin
                        if (cs_bad) begin
                            err_d = 1'b1;
                        end else begin
                            state_d   = SETUP;
                            cs_n_d    = cs_sel_mask;
                            mosi_d    = rw;
                            rw_d      = rw;
                            hdr_sh_d  = reg_addr;
                            hdr_cnt_d = HC_W'(ADDR_W);
                            tx_sh_d   = tx_data;
                            words_d   = eff_len;
                            in_data_d = 1'b0;
                            dbit_d    = '0;
                            phase_d   = 1'b0;
                            tx_req_d  = 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state_d = SHIFT;
                        sclk_d  = 1'b0;
                        phase_d = 1'b0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!phase_q) begin
                            // Rising edge: capture miso as it stood through the low phase.
                            sclk_d  = 1'b1;
                            phase_d = 1'b1;
                            if (in_data_q) begin
                                rx_sh_d = rx_next;
                                if (rw_q && word_end) begin
                                    rx_data_d  = rx_next;
                                    rx_valid_d = 1'b1;
                                end
                            end
                        end else if (last_bit) begin
                            state_d = TRAIL;
                            sclk_d  = CPOL;
                        end else begin
                            sclk_d  = 1'b0;
                            phase_d = 1'b0;
                            if (hdr_cnt_q != '0) begin
                                mosi_d    = hdr_sh_q[ADDR_W-1];
                                hdr_sh_d  = hdr_sh_q << 1;
                                hdr_cnt_d = hdr_cnt_q - 1'b1;
                            end else if (!in_data_q) begin
                                in_data_d = 1'b1;
                                dbit_d    = '0;
                                mosi_d    = !rw_q && tx_sh_q[DATA_W-1];
                                tx_sh_d   = tx_sh_q << 1;
                            end else if (word_end) begin
                                dbit_d   = '0;
                                words_d  = words_q - 1'b1;
                                mosi_d   = !rw_q && tx_data[DATA_W-1];
                                tx_sh_d  = tx_data << 1;
                                tx_req_d = !rw_q;
                            end else begin
                                dbit_d  = dbit_q + 1'b1;
                                mosi_d  = !rw_q && tx_sh_q[DATA_W-1];
                                tx_sh_d = tx_sh_q << 1;
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state_d = GAP;
                        cs_n_d  = '1;
                        mosi_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                GAP: begin
                    if (tick) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cs_n_d  = '1;
                    sclk_d  = CPOL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cs_n_q     <= '1;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            phase_q    <= 1'b0;
            in_data_q  <= 1'b0;
            rw_q       <= 1'b0;
            hdr_cnt_q  <= '0;
            hdr_sh_q   <= '0;
            tx_sh_q    <= '0;
            dbit_q     <= '0;
            words_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            phase_q    <= phase_d;
            in_data_q  <= in_data_d;
            rw_q       <= rw_d;
            hdr_cnt_q  <= hdr_cnt_d;
            hdr_sh_q   <= hdr_sh_d;
            tx_sh_q    <= tx_sh_d;
            dbit_q     <= dbit_d;
            words_q    <= words_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tx_req   = tx_req_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign err      = err_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_burst.sv
// Directed bench for spi_master_burst: mode 0 and mode 3 instances share stimulus, one monitored at a time.
// A frame/rx scoreboard is filled at launch and drained by the negedge monitor.
module tb_spi_master_burst;
    localparam int DIV = 5;

    typedef struct {
        logic [127:0] bits;
        int           nbits;
        int           low_cyc;
        logic [2:0]   cs_n;
        bit           chk;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, enable, start, rw, sel3;
    logic [1:0] cs_sel;
    logic [6:0] reg_addr;
    logic [3:0] burst_len;
    logic [7:0] tx_data;
    logic       miso = 1'b0;
    logic       start0, start3;

    logic       tx_req0, rx_valid0, busy0, done0, err0, sclk0, mosi0;
    logic       tx_req3, rx_valid3, busy3, done3, err3, sclk3, mosi3;
    logic [7:0] rx_data0, rx_data3;
    logic [2:0] cs_n0, cs_n3;

    logic       m_tx_req, m_rx_valid, m_busy, m_done, m_err, m_sclk, m_mosi;
    logic [7:0] m_rx_data;
    logic [2:0] m_cs_n;

    assign start0     = start & ~sel3;
    assign start3     = start & sel3;
    assign m_tx_req   = sel3 ? tx_req3 : tx_req0;
    assign m_rx_valid = sel3 ? rx_valid3 : rx_valid0;
    assign m_busy     = sel3 ? busy3 : busy0;
    assign m_done     = sel3 ? done3 : done0;
    assign m_err      = sel3 ? err3 : err0;
    assign m_sclk     = sel3 ? sclk3 : sclk0;
    assign m_mosi     = sel3 ? mosi3 : mosi0;
    assign m_rx_data  = sel3 ? rx_data3 : rx_data0;
    assign m_cs_n     = sel3 ? cs_n3 : cs_n0;

    spi_master_burst #(
        .CLK_HZ(50_000_000), .SPI_CLK(5_000_000), .SPI_MODE(0),
        .ADDR_W(7), .DATA_W(8), .MAX_BURST(8), .NUM_CS(3)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start0), .rw(rw),
        .cs_sel(cs_sel), .reg_addr(reg_addr), .burst_len(burst_len), .tx_data(tx_data),
        .tx_req(tx_req0), .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0),
        .done(done0), .err(err0), .sclk(sclk0), .mosi(mosi0), .miso(miso), .cs_n(cs_n0)
    );

    spi_master_burst #(
        .CLK_HZ(50_000_000), .SPI_CLK(5_000_000), .SPI_MODE(3),
        .ADDR_W(7), .DATA_W(8), .MAX_BURST(8), .NUM_CS(3)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start3), .rw(rw),
        .cs_sel(cs_sel), .reg_addr(reg_addr), .burst_len(burst_len), .tx_data(tx_data),
        .tx_req(tx_req3), .rx_data(rx_data3), .rx_valid(rx_valid3), .busy(busy3),
        .done(done3), .err(err3), .sclk(sclk3), .mosi(mosi3), .miso(miso), .cs_n(cs_n3)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0, txr_cnt = 0, rxv_cnt = 0, err_cnt = 0;
    int b_done, b_txr, b_rxv, b_err;

    logic [7:0]   words [8];
    frame_t       exp_f[$];
    logic [7:0]   exp_rx[$];

    int           tx_idx = 0;
    int           nrise = 0;
    int           low_cyc = 0;
    int           dpos;
    logic [127:0] obs_bits = '0;
    logic [2:0]   obs_cs = '1;
    logic         cs_low, prev_cs_low = 1'b0, prev_sclk = 1'b0;
    logic [7:0]   rx_e;
    frame_t       f_e;

    assign tx_data = words[tx_idx[2:0]];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Monitor, slave model and tx word feeder for the selected instance.
    always @(negedge clk) begin
        cs_low = ~&m_cs_n;
        if (!m_busy) tx_idx = 0;
        else if (m_tx_req) tx_idx = tx_idx + 1;
        if (m_tx_req) txr_cnt++;
        if (m_err) err_cnt++;
        if (m_done) begin
            done_cnt++;
            check("done_after_cs_release", 128'(cs_low), 128'(0));
        end
        if (m_rx_valid) begin
            rxv_cnt++;
            if (exp_rx.size() > 0) begin
                rx_e = exp_rx.pop_front();
                check("rx_data", 128'(m_rx_data), 128'(rx_e));
            end
        end
        if (cs_low) begin
            if (!prev_cs_low) begin
                obs_cs = m_cs_n; low_cyc = 0; nrise = 0; obs_bits = '0;
            end
            low_cyc++;
            if (m_sclk && !prev_sclk) begin
                obs_bits = {obs_bits[126:0], m_mosi};
                nrise++;
            end
            if (!m_sclk && prev_sclk && nrise >= 8) begin
                dpos = nrise - 8;
                miso = words[(dpos / 8) % 8][7 - (dpos % 8)];
            end
        end else if (prev_cs_low && exp_f.size() > 0) begin
            f_e = exp_f.pop_front();
            if (f_e.chk) begin
                check("mosi_stream", obs_bits, f_e.bits);
                check("bit_count", 128'(nrise), 128'(f_e.nbits));
                check("cs_low_cycles", 128'(low_cyc), 128'(f_e.low_cyc));
                check("cs_select", 128'(obs_cs), 128'(f_e.cs_n));
            end
        end
        prev_cs_low = cs_low;
        prev_sclk = m_sclk;
    end

    task automatic snap();
        b_done = done_cnt; b_txr = txr_cnt; b_rxv = rxv_cnt; b_err = err_cnt;
    endtask

    task automatic launch(input logic r, input logic [1:0] cs, input logic [6:0] a,
                          input logic [3:0] bl, input int n, input bit chk);
        frame_t f;
        f.bits = 128'({r, a});
        f.nbits = 8 + 8 * n;
        for (int i = 0; i < n; i++) begin
            f.bits = {f.bits[119:0], (r ? 8'h00 : words[i])};
            if (r) exp_rx.push_back(words[i]);
        end
        f.low_cyc = DIV * (2 + 2 * f.nbits);
        f.cs_n = ~(3'b001 << cs);
        f.chk = chk;
        exp_f.push_back(f);
        snap();
        rw = r; cs_sel = cs; reg_addr = a; burst_len = bl;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int e_done, input int e_txr, input int e_rxv);
        int k = 0;
        while (m_busy && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        check("busy_released", 128'(m_busy), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 128'(done_cnt - b_done), 128'(e_done));
        if (e_txr >= 0) check("tx_req_pulses", 128'(txr_cnt - b_txr), 128'(e_txr));
        check("rx_valid_pulses", 128'(rxv_cnt - b_rxv), 128'(e_rxv));
        check("no_err", 128'(err_cnt - b_err), 128'(0));
        check("rx_queue_drained", 128'(exp_rx.size()), 128'(0));
        check("frames_drained", 128'(exp_f.size()), 128'(0));
    endtask

    task automatic wait_rises(input int n);
        int k = 0;
        @(negedge clk); #1;
        while (nrise < n && k < 5000) begin
            @(negedge clk); #1;
            k++;
        end
        check("reached_bit", 128'(nrise >= n), 128'(1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cs_n"}, 128'(cs_n0), 128'(3'b111));
        check({tag, "_sclk_mode0"}, 128'(sclk0), 128'(0));
        check({tag, "_sclk_mode3"}, 128'(sclk3), 128'(1));
        check({tag, "_flags"}, 128'({busy0, done0, err0, tx_req0, rx_valid0, mosi0}), 128'(0));
        check({tag, "_rx_data"}, 128'(rx_data0), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; start = 1'b0; rw = 1'b0; sel3 = 1'b0;
        cs_sel = '0; reg_addr = '0; burst_len = '0;
        for (int i = 0; i < 8; i++) words[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1; enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: mode 0 single-word write 0x4B <- 0x01
        words[0] = 8'h01;
        launch(1'b0, 2'd0, 7'h4B, 4'd1, 1, 1'b1);
        wait_idle(1, 1, 0);

        // 2: 8-word read from 0x42
        for (int i = 0; i < 8; i++) words[i] = 8'h10 + 8'(i);
        launch(1'b1, 2'd0, 7'h42, 4'd8, 8, 1'b1);
        wait_idle(1, -1, 8);

        // 3: mode 3 instance, same write
        sel3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mode3_idle_sclk", 128'(m_sclk), 128'(1));
        words[0] = 8'h01;
        launch(1'b0, 2'd0, 7'h4B, 4'd1, 1, 1'b1);
        wait_idle(1, 1, 0);
        check("mode3_sclk_after_done", 128'(m_sclk), 128'(1));
        sel3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 4: enable dropped inside word 2 of a 4-word read
        for (int i = 0; i < 4; i++) words[i] = 8'h20 + 8'(i);
        launch(1'b1, 2'd1, 7'h42, 4'd4, 4, 1'b0);
        wait_rises(20);
        enable = 1'b0;
        @(posedge clk); #1;
        check("abort_cs_n", 128'(m_cs_n), 128'(3'b111));
        check("abort_busy", 128'(m_busy), 128'(0));
        enable = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", 128'(done_cnt - b_done), 128'(0));
        check("abort_rx_count", 128'(rxv_cnt - b_rxv), 128'(1));
        exp_rx.delete();
        words[0] = 8'hA5;
        launch(1'b0, 2'd2, 7'h11, 4'd1, 1, 1'b1);
        wait_idle(1, 1, 0);

        // 5: boundaries
        words[0] = 8'h3C;
        launch(1'b0, 2'd0, 7'h05, 4'd0, 1, 1'b1);
        wait_idle(1, 1, 0);
        for (int i = 0; i < 8; i++) words[i] = 8'h80 + 8'(i);
        launch(1'b1, 2'd1, 7'h40, 4'd15, 8, 1'b1);
        wait_idle(1, -1, 8);
        words[0] = 8'h5A;
        launch(1'b0, 2'd0, 7'h22, 4'd1, 1, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        rw = 1'b1; cs_sel = 2'd2; reg_addr = 7'h7E; burst_len = 4'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(1, 1, 0);
        check("start_busy_no_restart", 128'(m_busy), 128'(0));
        snap();
        cs_sel = 2'd3; rw = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("bad_cs_err", 128'(m_err), 128'(1));
        check("bad_cs_cs_n", 128'(m_cs_n), 128'(3'b111));
        check("bad_cs_busy", 128'(m_busy), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        check("bad_cs_err_once", 128'(err_cnt - b_err), 128'(1));
        snap();
        cs_sel = 2'd0; enable = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; enable = 1'b1;
        check("disabled_start_busy", 128'(m_busy), 128'(0));
        check("disabled_start_err", 128'(err_cnt - b_err), 128'(0));

        // 6: one-cycle reset inside the header, then a clean 2-word write
        words[0] = 8'h77;
        launch(1'b0, 2'd0, 7'h33, 4'd1, 1, 1'b0);
        wait_rises(3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_values("midreset");
        repeat (5) @(posedge clk);
        #1;
        check("midreset_no_done", 128'(done_cnt - b_done), 128'(0));
        words[0] = 8'hC3; words[1] = 8'h3C;
        launch(1'b0, 2'd1, 7'h7F, 4'd2, 2, 1'b1);
        wait_idle(1, 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_burst.md
Name: spi_master_burst

Overview:
Parametrised SPI master for the magnetometer sensor path. Runs one register-access transaction per start: an R/W header bit, an ADDR_W-bit address, then 1..MAX_BURST data words. Supports SPI mode 0 or 3, multiple chip selects, and a streaming TX/RX word interface for burst reads of the XYZ/RHALL block.
It sits between the sensor-control FSM and the SPI pads.

Parameters:
CLK_HZ, 50_000_000, system clock frequency (Hz)
SPI_CLK, 5_000_000, target SCLK frequency (Hz); DIVIDER = CLK_HZ/(2*SPI_CLK), must be >= 1 (elaboration assertion)
SPI_MODE, 0, 0 = CPOL0/CPHA0, 3 = CPOL1/CPHA1; any other value is an elaboration error
ADDR_W, 7, address bits following the R/W bit
DATA_W, 8, bits per data word
MAX_BURST, 8, maximum words per transaction
NUM_CS, 2, number of chip selects

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable  in  1  block enable; low aborts any transaction
start  in  1  transaction request, accepted only in IDLE with enable high
rw  in  1  0 = write, 1 = read; sent as the header bit
cs_sel  in  $clog2(NUM_CS) (min 1)  target chip-select index
reg_addr  in  ADDR_W  start register address
burst_len  in  $clog2(MAX_BURST+1)  word count
tx_data  in  DATA_W  current write word
tx_req  out  1  one-cycle pulse: tx_data latched, present next word
rx_data  out  DATA_W  last received word
rx_valid  out  1  one-cycle pulse: rx_data updated
busy  out  1  high from start accept until return to IDLE
done  out  1  one-cycle pulse at normal completion
err  out  1  one-cycle pulse: start rejected
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE; busy, done, err, tx_req, rx_valid all 0; rx_data 0; mosi 0.
  - cs_n all 1; sclk = CPOL (0 for mode 0, 1 for mode 3).
  - Divider counter 0.
- Applies equally mid-transaction; no done is pulsed.
- Half-period tick: counter runs only outside IDLE, restarts at 0 on start accept, and ticks every DIVIDER cycles.
- Start accept (IDLE, enable, start):
  - Latch rw, cs_sel, reg_addr, tx_data (word 0, with tx_req pulse the next cycle) and effective length N.
  - N = 1 if burst_len == 0; N = MAX_BURST if burst_len > MAX_BURST.
  - If cs_sel >= NUM_CS: pulse err and stay IDLE.
- States:
  - IDLE: waits for start accept.
  - SETUP: selected cs_n low, mosi = rw; lasts 1 half-period.
  - SHIFT: 1+ADDR_W+DATA_W*N bits, MSB first.
  - TRAIL: cs_n still low; lasts 1 half-period.
  - GAP: cs_n high, done pulsed in its first cycle; lasts 1 half-period, then IDLE.
- Bit timing in SHIFT: each bit is a low phase then a high phase (1 half-period each).
  - mosi changes at the start of the low phase, except bit 0, which is already driven in SETUP.
  - miso is sampled at the rising edge.
  - Mode 0: sclk idle 0. Mode 3: sclk idle 1, falls at SETUP exit, and returns high after the last bit.
- Data bits:
  - Write: tx word, MSB first. Each word boundary latches the next tx_data and pulses tx_req; no tx_req after the last word.
  - Read: mosi = 0. rx_data is updated and rx_valid pulsed the cycle after each word's final sample.
- cs_n low duration = DIVIDER*(2 + 2*(1+ADDR_W+DATA_W*N)) cycles. Example: DIVIDER 5, ADDR_W 7, DATA_W 8, N 1 gives 170 cycles.
- start while busy (or in GAP) is ignored; no err is pulsed.
- enable low in any non-IDLE state, on the next edge:
  - IDLE; cs_n all 1; sclk = CPOL; busy 0.
  - No done, rx_valid or tx_req.
- start and enable falling in the same cycle: not accepted.

Decomposition:
- Package spi_pkg: state_t enum (IDLE, SETUP, SHIFT, TRAIL, GAP), SPI mode constants, and a divider-computation function.
- Sub-module spi_sclk_tick: divider counter with clear input and half-period tick output, reused by future SPI blocks.

Test Plan:
1. Mode 0, DIVIDER 5, write 0x4B <- 0x01 -> mosi 0,1001011,00000001 at rising edges; cs_n[0] low 170 cycles; one done; one tx_req; no rx_valid.
2. Read 0x42, burst_len 8, slave model returns 0x10..0x17 -> 8 rx_valid pulses with data 0x10..0x17 in order; mosi 0 during data; done once after cs_n rises.
3. SPI_MODE 3 instance, same write as test 1 -> sclk idle 1, identical sampled bit stream, sclk high in IDLE after done.
4. enable dropped mid word 2 of a 4-word read -> cs_n high and busy low next cycle, no done. Next transaction is bit-exact.
5. Boundaries:
   - burst_len 0 -> 1 word.
   - burst_len 15 -> 8 words.
   - start during busy -> ignored.
   - cs_sel = NUM_CS -> err pulse, cs_n all high.
6. rst_n low mid-header for 1 cycle -> all outputs at reset values next cycle. A subsequent write completes correctly.
